poly_key_tracker: RTL and testbench

- Successor to the single-key scan-code decoder for the C-scale piano.
- Consumes the PS/2 controller's received-byte stream and decodes make codes, break codes (0xF0 prefix) and extended codes (0xE0 prefix).
- Tracks up to NUM_VOICES simultaneously held keys. Presents per-voice key indices to the tone generators, plus a legacy mono output.
- Sits between PS2_Controller and the audio voice bank.

---
 rtl/piano_pkg.sv | 38 +++
 rtl/poly_key_tracker_if.sv | 24 ++
 rtl/scan_to_key.sv | 36 +++
 rtl/poly_key_tracker.sv | 156 +++++++++++++++
 tb/tb_poly_key_tracker.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano keyboard front-end: PS/2 prefixes,
// the scan codes of the playable keys and the prefix-tracking FSM states.
package piano_pkg;
  localparam int KEY_W = 5;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_TWO   = 8'h1E;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_THREE = 8'h26;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_FOUR  = 8'h25;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_FIVE  = 8'h2E;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_SIX   = 8'h36;
  localparam logic [7:0] SC_Y     = 8'h35;
  localparam logic [7:0] SC_SEVEN = 8'h3D;
  localparam logic [7:0] SC_U     = 8'h3C;
  localparam logic [7:0] SC_EIGHT = 8'h3E;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_O     = 8'h44;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;
endpackage

// File: rtl/poly_key_tracker_if.sv
// Byte stream in from the PS/2 controller, per-voice key state out to the voice bank.
interface poly_key_tracker_if #(
  parameter int NUM_VOICES = 4,
  parameter int CODE_W     = 5
);
  logic [7:0]                   byte_in;
  logic                         byte_en;
  logic                         clear_all;
  logic [NUM_VOICES*CODE_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]        voice_active;
  logic [CODE_W-1:0]            last_key;
  logic                         key_event;
  logic                         steal;

  modport master (
    output byte_in, byte_en, clear_all,
    input  voice_key, voice_active, last_key, key_event, steal
  );

  modport slave (
    input  byte_in, byte_en, clear_all,
    output voice_key, voice_active, last_key, key_event, steal
  );
endinterface

// File: rtl/scan_to_key.sv
// Scan code to piano key index; unmapped codes give 0 ("no key").
module scan_to_key
  import piano_pkg::*;
(
  input  logic [7:0]       scan,
  output logic [KEY_W-1:0] key
);
  always_comb begin
    key = '0;
    unique case (scan)
      SC_Q:     key = 5'd1;
      SC_TWO:   key = 5'd2;
      SC_W:     key = 5'd3;
      SC_THREE: key = 5'd4;
      SC_E:     key = 5'd5;
      SC_FOUR:  key = 5'd6;
      SC_R:     key = 5'd7;
      SC_FIVE:  key = 5'd8;
      SC_T:     key = 5'd9;
      SC_SIX:   key = 5'd10;
      SC_Y:     key = 5'd11;
      SC_SEVEN: key = 5'd12;
      SC_U:     key = 5'd13;
      SC_EIGHT: key = 5'd14;
      SC_I:     key = 5'd15;
      SC_A:     key = 5'd16;
      SC_S:     key = 5'd17;
      SC_D:     key = 5'd18;
      SC_F:     key = 5'd19;
      SC_G:     key = 5'd20;
      SC_H:     key = 5'd21;
      SC_O:     key = 5'd22;
      default:  key = '0;
    endcase
  end
endmodule

// File: rtl/poly_key_tracker.sv
// Polyphonic PS/2 key tracker: decodes make/break/extended sequences and
// keeps up to NUM_VOICES held keys in slots, stealing round-robin when full.
module poly_key_tracker
  import piano_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int CODE_W      = 5,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  poly_key_tracker_if.slave bus
);
  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_VOICES - 1);

  logic [NUM_VOICES-1:0][CODE_W-1:0] slot_key_q, slot_key_d;
  logic [NUM_VOICES-1:0]             slot_act_q, slot_act_d;
  logic [CODE_W-1:0]                 last_key_q, last_key_d;
  logic                              key_event_q, key_event_d;
  logic                              steal_q, steal_d;
  kbd_state_e                        state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [PTR_W-1:0]                  steal_ptr_q, steal_ptr_d;

  logic [KEY_W-1:0]      map_key;
  logic [CODE_W-1:0]     key;
  logic [NUM_VOICES-1:0] hit;
  logic                  free_any;
  logic [PTR_W-1:0]      free_idx, hit_idx;

  scan_to_key u_scan_to_key (
    .scan (bus.byte_in),
    .key  (map_key)
  );

  assign key = CODE_W'(map_key);

  for (genvar s = 0; s < NUM_VOICES; s++) begin : g_hit
    assign hit[s] = slot_act_q[s] && (slot_key_q[s] == key);
  end

  // Descending scans leave the lowest matching index in the result.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    hit_idx  = '0;
    for (int s = NUM_VOICES - 1; s >= 0; s--) begin
      if (!slot_act_q[s]) begin
        free_any = 1'b1;
        free_idx = PTR_W'(s);
      end
      if (hit[s]) hit_idx = PTR_W'(s);
    end
  end

  always_comb begin
    slot_key_d  = slot_key_q;
    slot_act_d  = slot_act_q;
    last_key_d  = last_key_q;
    key_event_d = 1'b0;
    steal_d     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    steal_ptr_d = steal_ptr_q;

    // A dangling prefix is abandoned after a long idle gap.
    if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (bus.byte_en) begin
      cnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          if (bus.byte_in == PS2_BREAK) begin
            state_d = ST_BRK;
          end else if (bus.byte_in == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (key != '0 && hit == '0) begin
            if (free_any) begin
              slot_key_d[free_idx] = key;
              slot_act_d[free_idx] = 1'b1;
            end else begin
              slot_key_d[steal_ptr_q] = key;
              steal_d     = 1'b1;
              steal_ptr_d = (steal_ptr_q == PTR_LAST) ? '0 : steal_ptr_q + 1'b1;
            end
            last_key_d  = key;
            key_event_d = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (key != '0 && hit != '0) begin
            slot_key_d[hit_idx] = '0;
            slot_act_d[hit_idx] = 1'b0;
            key_event_d         = 1'b1;
            if (last_key_q == key) last_key_d = '0;
          end
        end
        ST_EXT:     state_d = (bus.byte_in == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end

    // Panic release wins over any coincident byte.
    if (bus.clear_all) begin
      slot_key_d  = '0;
      slot_act_d  = '0;
      last_key_d  = '0;
      key_event_d = |slot_act_q;
      steal_d     = 1'b0;
      state_d     = ST_IDLE;
      cnt_d       = '0;
      steal_ptr_d = steal_ptr_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      slot_key_q  <= '0;
      slot_act_q  <= '0;
      last_key_q  <= '0;
      key_event_q <= 1'b0;
      steal_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      steal_ptr_q <= '0;
    end else begin
      slot_key_q  <= slot_key_d;
      slot_act_q  <= slot_act_d;
      last_key_q  <= last_key_d;
      key_event_q <= key_event_d;
      steal_q     <= steal_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      steal_ptr_q <= steal_ptr_d;
    end
  end

  assign bus.voice_key    = slot_key_q;
  assign bus.voice_active = slot_act_q;
  assign bus.last_key     = last_key_q;
  assign bus.key_event    = key_event_q;
  assign bus.steal        = steal_q;
endmodule

// File: tb/tb_poly_key_tracker.sv
// Directed bench for poly_key_tracker with a shortened prefix timeout.
module tb_poly_key_tracker;
  localparam int NV = 4;
  localparam int CW = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   ev_cnt = 0;
  int   st_cnt = 0;
  int   ev_base, st_base;

  always #10 clk = ~clk;

  poly_key_tracker_if #(.NUM_VOICES(NV), .CODE_W(CW)) bus ();

  poly_key_tracker #(.NUM_VOICES(NV), .CODE_W(CW), .TIMEOUT_CYC(TO)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always @(negedge clk) begin
    if (bus.key_event) ev_cnt++;
    if (bus.steal)     st_cnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns at the negedge after the capture edge, where pulses are visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in = b; bus.byte_en = 1'b1;
    @(negedge clk);
    bus.byte_en = 1'b0; bus.byte_in = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    bus.byte_in = 8'h00; bus.byte_en = 1'b0; bus.clear_all = 1'b0;
    do_reset();
    checks++; if (bus.voice_active !== 4'b0000) $display("FAIL reset_active: got %b exp 0000", bus.voice_active); else passes++;
    checks++; if (bus.voice_key !== 20'h0) $display("FAIL reset_key: got %h exp 0", bus.voice_key); else passes++;
    checks++; if (bus.last_key !== 5'd0) $display("FAIL reset_last: got %0d exp 0", bus.last_key); else passes++;
    checks++; if (bus.key_event !== 1'b0 || bus.steal !== 1'b0) $display("FAIL reset_pulses: got ev=%b st=%b exp 0 0", bus.key_event, bus.steal); else passes++;
    // Reset after a break prefix: next byte must be a make.
    send(8'hF0);
    do_reset();
    send(8'h15);
    checks++; if (bus.voice_active !== 4'b0001) $display("FAIL reset_mid_seq: got %b exp 0001", bus.voice_active); else passes++;
  endtask

  task automatic test_single_make();
    do_reset();
    send(8'h15);
    checks++; if (bus.voice_key !== 20'h00001) $display("FAIL make_key: got %h exp 00001", bus.voice_key); else passes++;
    checks++; if (bus.voice_active !== 4'b0001) $display("FAIL make_active: got %b exp 0001", bus.voice_active); else passes++;
    checks++; if (bus.last_key !== 5'd1) $display("FAIL make_last: got %0d exp 1", bus.last_key); else passes++;
    checks++; if (bus.key_event !== 1'b1) $display("FAIL make_event: got %b exp 1", bus.key_event); else passes++;
    idle(1);
    checks++; if (bus.key_event !== 1'b0) $display("FAIL make_event_width: got %b exp 0", bus.key_event); else passes++;
  endtask

  task automatic test_repeat();
    do_reset();
    ev_base = ev_cnt;
    send(8'h15); send(8'h15); send(8'h15);
    idle(2);
    checks++; if (bus.voice_key !== 20'h00001 || bus.voice_active !== 4'b0001) $display("FAIL repeat_slots: got %h/%b exp 00001/0001", bus.voice_key, bus.voice_active); else passes++;
    checks++; if (ev_cnt - ev_base !== 1) $display("FAIL repeat_events: got %0d exp 1", ev_cnt - ev_base); else passes++;
    send(8'hF0); send(8'h15);
    idle(2);
    checks++; if (bus.voice_active !== 4'b0000 || bus.last_key !== 5'd0) $display("FAIL repeat_release: got %b/%0d exp 0000/0", bus.voice_active, bus.last_key); else passes++;
    checks++; if (ev_cnt - ev_base !== 2) $display("FAIL repeat_release_events: got %0d exp 2", ev_cnt - ev_base); else passes++;
  endtask

  task automatic test_break_last();
    do_reset();
    send(8'h15); send(8'h1D);
    send(8'hF0); send(8'h15);
    idle(1);
    checks++; if (bus.voice_active !== 4'b0010 || bus.last_key !== 5'd3) $display("FAIL brk_other: got %b/%0d exp 0010/3", bus.voice_active, bus.last_key); else passes++;
    send(8'hF0); send(8'h1D);
    idle(1);
    checks++; if (bus.voice_active !== 4'b0000 || bus.last_key !== 5'd0) $display("FAIL brk_last: got %b/%0d exp 0000/0", bus.voice_active, bus.last_key); else passes++;
    // Unmapped make and break of a non-held key are silent.
    ev_base = ev_cnt;
    send(8'h75); send(8'hF0); send(8'h24);
    idle(2);
    checks++; if (ev_cnt - ev_base !== 0 || bus.voice_active !== 4'b0000) $display("FAIL ignored_bytes: got ev=%0d act=%b exp 0/0000", ev_cnt - ev_base, bus.voice_active); else passes++;
  endtask

  task automatic test_steal();
    do_reset();
    st_base = st_cnt;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    idle(1);
    checks++; if (bus.voice_key !== {5'd7, 5'd5, 5'd3, 5'd1} || bus.voice_active !== 4'b1111) $display("FAIL fill_slots: got %h/%b exp %h/1111", bus.voice_key, bus.voice_active, {5'd7, 5'd5, 5'd3, 5'd1}); else passes++;
    send(8'h2C);
    checks++; if (bus.steal !== 1'b1) $display("FAIL steal_pulse: got %b exp 1", bus.steal); else passes++;
    checks++; if (bus.voice_key !== {5'd7, 5'd5, 5'd3, 5'd9} || bus.last_key !== 5'd9) $display("FAIL steal_slot0: got %h/%0d exp %h/9", bus.voice_key, bus.last_key, {5'd7, 5'd5, 5'd3, 5'd9}); else passes++;
    send(8'h35);
    idle(1);
    checks++; if (bus.voice_key !== {5'd7, 5'd5, 5'd11, 5'd9} || bus.last_key !== 5'd11) $display("FAIL steal_slot1: got %h/%0d exp %h/11", bus.voice_key, bus.last_key, {5'd7, 5'd5, 5'd11, 5'd9}); else passes++;
    checks++; if (st_cnt - st_base !== 2) $display("FAIL steal_count: got %0d exp 2", st_cnt - st_base); else passes++;
    // clear_all keeps the steal pointer at slot 2.
    @(negedge clk); bus.clear_all = 1'b1;
    @(negedge clk); bus.clear_all = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    idle(1);
    checks++; if (bus.voice_key !== {5'd7, 5'd9, 5'd3, 5'd1}) $display("FAIL steal_ptr_kept: got %h exp %h", bus.voice_key, {5'd7, 5'd9, 5'd3, 5'd1}); else passes++;
  endtask

  task automatic test_ext();
    do_reset();
    send(8'h15);
    idle(1);
    ev_base = ev_cnt;
    send(8'hE0); send(8'hF0); send(8'h15);
    idle(2);
    checks++; if (bus.voice_key !== 20'h00001 || bus.voice_active !== 4'b0001) $display("FAIL ext_brk_hold: got %h/%b exp 00001/0001", bus.voice_key, bus.voice_active); else passes++;
    checks++; if (ev_cnt - ev_base !== 0) $display("FAIL ext_brk_events: got %0d exp 0", ev_cnt - ev_base); else passes++;
    send(8'hE0); send(8'h75);
    idle(2);
    checks++; if (bus.voice_active !== 4'b0001 || ev_cnt - ev_base !== 0) $display("FAIL ext_make: got %b/%0d exp 0001/0", bus.voice_active, ev_cnt - ev_base); else passes++;
    send(8'h1D);
    checks++; if (bus.voice_active !== 4'b0011 || bus.last_key !== 5'd3) $display("FAIL ext_back_idle: got %b/%0d exp 0011/3", bus.voice_active, bus.last_key); else passes++;
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hF0);
    idle(TO + 2);
    send(8'h1C);
    checks++; if (bus.voice_key !== 20'h00010 || bus.voice_active !== 4'b0001 || bus.last_key !== 5'd16) $display("FAIL timeout_make: got %h/%b/%0d exp 00010/0001/16", bus.voice_key, bus.voice_active, bus.last_key); else passes++;
    send(8'hF0);
    idle(TO - 6);
    send(8'h1C);
    checks++; if (bus.voice_active !== 4'b0000 || bus.key_event !== 1'b1) $display("FAIL before_timeout_brk: got %b/%b exp 0000/1", bus.voice_active, bus.key_event); else passes++;
  endtask

  task automatic test_clear();
    do_reset();
    send(8'h15); send(8'h1D); send(8'h2D);
    idle(1);
    ev_base = ev_cnt;
    @(negedge clk);
    bus.clear_all = 1'b1; bus.byte_in = 8'h24; bus.byte_en = 1'b1;
    @(negedge clk);
    bus.clear_all = 1'b0; bus.byte_en = 1'b0; bus.byte_in = 8'h00;
    checks++; if (bus.key_event !== 1'b1) $display("FAIL clear_event: got %b exp 1", bus.key_event); else passes++;
    checks++; if (bus.voice_active !== 4'b0000 || bus.voice_key !== 20'h0 || bus.last_key !== 5'd0) $display("FAIL clear_state: got %b/%h/%0d exp 0000/0/0", bus.voice_active, bus.voice_key, bus.last_key); else passes++;
    idle(2);
    checks++; if (ev_cnt - ev_base !== 1) $display("FAIL clear_event_count: got %0d exp 1", ev_cnt - ev_base); else passes++;
    @(negedge clk); bus.clear_all = 1'b1;
    @(negedge clk); bus.clear_all = 1'b0;
    idle(1);
    checks++; if (ev_cnt - ev_base !== 1) $display("FAIL clear_empty_event: got %0d exp 1", ev_cnt - ev_base); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_repeat();
    test_break_last();
    test_steal();
    test_ext();
    test_timeout();
    test_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
